muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_if.sv | 20 ++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// EX-stage bus between the pipeline and muldiv_unit: decode fields, operands,
// flush, and the stall/done/result/HI/LO return path.
interface muldiv_unit_if #(parameter int WIDTH = 32);
   logic             valid_i;
   logic [5:0]       op;
   logic [5:0]       funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             stall_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (output valid_i, op, funct, a, b, flush,
                   input  stall_o, done_o, result_o, hi_o, lo_o);
   modport slave  (input  valid_i, op, funct, a, b, flush,
                   output stall_o, done_o, result_o, hi_o, lo_o);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding HI/LO; shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle multiplier and skip RUN.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] hacc_q, hacc_d, lacc_q, lacc_d, opnd_q, opnd_d;
   logic             is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;

   logic is_special, is_mult, is_multu, is_div, is_divu;
   logic is_mfhi, is_mthi, is_mflo, is_mtlo, is_md, md_div, md_signed, issue;
   logic a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign is_special = (bus.op == 6'b000000);
   assign is_mult    = is_special && (bus.funct == 6'b011000);
   assign is_multu   = is_special && (bus.funct == 6'b011001);
   assign is_div     = is_special && (bus.funct == 6'b011010);
   assign is_divu    = is_special && (bus.funct == 6'b011011);
   assign is_mfhi    = is_special && (bus.funct == 6'b010000);
   assign is_mthi    = is_special && (bus.funct == 6'b010001);
   assign is_mflo    = is_special && (bus.funct == 6'b010010);
   assign is_mtlo    = is_special && (bus.funct == 6'b010011);
   assign is_md      = is_mult | is_multu | is_div | is_divu;
   assign md_div     = is_div | is_divu;
   assign md_signed  = is_mult | is_div;
   assign issue      = (state_q == IDLE) & bus.valid_i & is_md & ~bus.flush;

   // Signed ops run on magnitudes; the sign is restored in FIX.
   assign a_neg = md_signed & bus.a[WIDTH-1];
   assign b_neg = md_signed & bus.b[WIDTH-1];
   assign mag_a = a_neg ? -bus.a : bus.a;
   assign mag_b = b_neg ? -bus.b : bus.b;

   // Shift-add step: hacc:lacc is the partial product, multiplier bits in lacc.
   logic [WIDTH:0]   add_sum;
   logic [WIDTH-1:0] mul_hi, mul_lo;
   assign add_sum = {1'b0, hacc_q} + (lacc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_hi  = add_sum[WIDTH:1];
   assign mul_lo  = {add_sum[0], lacc_q[WIDTH-1:1]};

   // Restoring step: hacc is the remainder, lacc shifts dividend out / quotient in.
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] trial, div_hi, div_lo;
   logic             ge;
   assign rem_sh = {hacc_q, lacc_q[WIDTH-1]};
   assign ge     = (rem_sh >= {1'b0, opnd_q});
   assign trial  = rem_sh[WIDTH-1:0] - opnd_q;
   assign div_hi = ge ? trial : rem_sh[WIDTH-1:0];
   assign div_lo = {lacc_q[WIDTH-2:0], ge};

   logic [2*WIDTH-1:0] prod, prod_fix;
   assign prod     = {hacc_q, lacc_q};
   assign prod_fix = neg_lo_q ? -prod : prod;

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      hacc_d   = hacc_q;
      lacc_d   = lacc_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      if (bus.flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (issue) begin
                  count_d  = '0;
                  is_div_d = md_div;
                  opnd_d   = md_div ? mag_b : mag_a;
                  neg_hi_d = a_neg;
                  // Divide by zero keeps the all-ones quotient unsigned; remainder returns a.
                  neg_lo_d = (md_div && bus.b == '0) ? 1'b0 : (a_neg ^ b_neg);
`ifdef MULDIV_FAST_MUL_EN
                  if (!md_div) begin
                     {hacc_d, lacc_d} = fast_prod;
                     state_d          = FIX;
                  end else begin
                     hacc_d  = '0;
                     lacc_d  = mag_a;
                     state_d = RUN;
                  end
`else
                  hacc_d  = '0;
                  lacc_d  = md_div ? mag_a : mag_b;
                  state_d = RUN;
`endif
               end else if (bus.valid_i && is_mthi) begin
                  hi_d = bus.a;
               end else if (bus.valid_i && is_mtlo) begin
                  lo_d = bus.a;
               end
            end
            RUN: begin
               hacc_d  = is_div_q ? div_hi : mul_hi;
               lacc_d  = is_div_q ? div_lo : mul_lo;
               count_d = count_q + 1'b1;
               if (count_q == LAST) state_d = FIX;
            end
            FIX: begin
               if (is_div_q) begin
                  lo_d = neg_lo_q ? -lacc_q : lacc_q;
                  hi_d = neg_hi_q ? -hacc_q : hacc_q;
               end else begin
                  {hi_d, lo_d} = prod_fix;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         hacc_q   <= '0;
         lacc_q   <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         hacc_q   <= hacc_d;
         lacc_q   <= lacc_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
      end
   end

   assign bus.stall_o  = issue | (state_q == RUN);
   assign bus.done_o   = (state_q == FIX) & ~bus.flush;
   assign bus.result_o = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);
   assign bus.hi_o     = hi_q;
   assign bus.lo_o     = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops vs. an
// arithmetic reference model, and flush/reset/MTHI/MTLO sequences.
module tb_muldiv_unit;
   localparam int W = 32;
   localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                          F_DIVU = 6'b011011, F_MFHI = 6'b010000, F_MTHI = 6'b010001,
                          F_MFLO = 6'b010010, F_MTLO = 6'b010011;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 1;
`endif
   localparam int DIV_LAT = W + 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(W)) bus ();
   muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bus_idle();
      bus.valid_i = 1'b0; bus.op = 6'd0; bus.funct = 6'd0;
      bus.a = '0; bus.b = '0; bus.flush = 1'b0;
   endtask

   // Reference: plain arithmetic on the architectural definition.
   function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      logic [63:0] p;
      longint sa, sb, q, r;
      hi = '0; lo = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f)
         F_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
         F_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
         F_DIVU:  if (b == 0) begin lo = '1; hi = a; end else begin lo = a / b; hi = a % b; end
         F_DIV:   if (b == 0) begin lo = '1; hi = a; end
                  else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
         default: ;
      endcase
   endfunction

   // Call just after a negedge; issues in this cycle and checks latency and results.
   task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      int cyc, stalls, lat;
      bit got;
      lat = (f == F_MULT || f == F_MULTU) ? MUL_LAT : DIV_LAT;
      bus.valid_i = 1'b1; bus.op = 6'd0; bus.funct = f; bus.a = a; bus.b = b;
      #1;
      chk({nm, " stall_at_issue"}, bus.stall_o, 1'b1);
      stalls = 1; cyc = 0; got = 1'b0;
      while (!got && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (bus.done_o) got = 1'b1;
         else if (bus.stall_o) stalls++;
         bus.valid_i = 1'b0;
      end
      chk({nm, " done_latency"}, cyc, lat);
      chk({nm, " stall_cycles"}, stalls, lat);
      @(negedge clk);
      chk({nm, " done_pulse_ends"}, bus.done_o, 1'b0);
      chk({nm, " hi"}, bus.hi_o, eh);
      chk({nm, " lo"}, bus.lo_o, el);
      bus.valid_i = 1'b1; bus.funct = F_MFHI;
      #1 chk({nm, " mfhi"}, bus.result_o, eh);
      bus.funct = F_MFLO;
      #1 chk({nm, " mflo"}, bus.result_o, el);
      bus.valid_i = 1'b0; bus.funct = 6'd0;
   endtask

   typedef struct {
      logic [5:0]  f;
      logic [31:0] a, b, hi, lo;
   } vec_t;

   initial begin
      vec_t tbl[10];
      logic [31:0] eh, el, hold_hi, hold_lo;
      logic [5:0] rf;
      logic [31:0] ra, rb;
      int pulses;

      tbl[0] = '{F_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
      tbl[1] = '{F_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
      tbl[2] = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[3] = '{F_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
      tbl[4] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
      tbl[5] = '{F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
      tbl[6] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
      tbl[7] = '{F_DIVU,  32'd100,      32'd3,        32'd1,        32'd33};
      tbl[8] = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      tbl[9] = '{F_MULTU, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 32'h242D2080};

      bus_idle();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset stall", bus.stall_o, 1'b0);
      chk("reset done", bus.done_o, 1'b0);
      chk("reset hi", bus.hi_o, 32'd0);
      chk("reset lo", bus.lo_o, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);
      end

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0: rf = F_MULT; 1: rf = F_MULTU; 2: rf = F_DIV; default: rf = F_DIVU;
         endcase
         ra = $urandom;
         case ($urandom_range(0, 9))
            0: rb = 32'd0;
            1: rb = 32'hFFFFFFFF;
            2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            3: rb = $urandom_range(1, 15);
            default: rb = $urandom;
         endcase
         model(rf, ra, rb, eh, el);
         @(negedge clk);
         run_op($sformatf("rnd%0d", i), rf, ra, rb, eh, el);
      end

      // MTHI/MTLO write at the edge; MFHI/MFLO read the next cycle.
      @(negedge clk);
      bus.valid_i = 1'b1; bus.funct = F_MTHI; bus.a = 32'h1234;
      #1 chk("mthi no stall", bus.stall_o, 1'b0);
      @(negedge clk);
      bus.funct = F_MFHI;
      #1 chk("mfhi after mthi", bus.result_o, 32'h1234);
      @(negedge clk);
      bus.funct = F_MTLO; bus.a = 32'h5678;
      @(negedge clk);
      bus.funct = F_MFLO;
      #1 chk("mflo after mtlo", bus.result_o, 32'h5678);
      chk("mtlo keeps hi", bus.hi_o, 32'h1234);
      bus_idle();

      // Flush mid-divide: stall drops, no done, HI/LO untouched.
      @(negedge clk);
      hold_hi = bus.hi_o; hold_lo = bus.lo_o;
      bus.valid_i = 1'b1; bus.funct = F_DIVU; bus.a = 32'd100; bus.b = 32'd3;
      @(negedge clk);
      bus_idle();
      repeat (8) @(negedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      #1 chk("flush cycle no done", bus.done_o, 1'b0);
      @(negedge clk);
      bus.flush = 1'b0;
      #1 chk("post flush stall", bus.stall_o, 1'b0);
      pulses = 0;
      repeat (40) begin @(negedge clk); if (bus.done_o) pulses++; end
      chk("flush no done", pulses, 0);
      chk("flush hi kept", bus.hi_o, hold_hi);
      chk("flush lo kept", bus.lo_o, hold_lo);

      // Flush together with issue: never accepted.
      @(negedge clk);
      bus.valid_i = 1'b1; bus.funct = F_MULTU; bus.a = 32'd9; bus.b = 32'd9; bus.flush = 1'b1;
      #1 chk("flush+issue stall", bus.stall_o, 1'b0);
      @(negedge clk);
      bus_idle();
      #1 chk("flush+issue idle", bus.stall_o, 1'b0);
      pulses = 0;
      repeat (40) begin @(negedge clk); if (bus.done_o) pulses++; end
      chk("flush+issue no done", pulses, 0);
      chk("flush+issue lo kept", bus.lo_o, hold_lo);

      // Reset in the middle of RUN, then a new MULTU the cycle reset drops.
      @(negedge clk);
      bus.valid_i = 1'b1; bus.funct = F_MULTU; bus.a = 32'd5; bus.b = 32'd6;
      @(negedge clk);
      bus_idle();
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrun rst stall", bus.stall_o, 1'b0);
      chk("midrun rst done", bus.done_o, 1'b0);
      chk("midrun rst hi", bus.hi_o, 32'd0);
      chk("midrun rst lo", bus.lo_o, 32'd0);
      rst = 1'b0;
      run_op("after_rst", F_MULTU, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
